// File: rtl/fft_peak_phase.sv
// fft_peak_phase: tracks the largest in-range bin of each sof..last frame and reports its index, magnitude and phase.
module fft_peak_phase #(
    parameter int          N_FFT      = 1024,
    parameter int          IDX_W      = 10,
    parameter int          MIN_BIN    = 1,
    parameter int          MAX_BIN    = 511,
    parameter logic [31:0] MAG_THRESH = 32'd1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bin_valid,
    input  logic             bin_sof,
    input  logic             bin_last,
    input  logic [IDX_W-1:0] bin_index,
    input  logic [31:0]      bin_mag,
    input  logic [16:0]      bin_phase,
    output logic [16:0]      theta_o,
    output logic [IDX_W-1:0] peak_index,
    output logic [31:0]      peak_mag,
    output logic             peak_valid,
    output logic             max_done,
    output logic             frame_err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      best_mag_q, best_mag_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [16:0]      best_phase_q, best_phase_d;
    logic             found_q, found_d;
    logic [16:0]      theta_q, theta_d;
    logic [IDX_W-1:0] peak_index_q, peak_index_d;
    logic [31:0]      peak_mag_q, peak_mag_d;
    logic             peak_valid_q, peak_valid_d;
    logic             max_done_q, max_done_d;
    logic             frame_err_q, frame_err_d;
    logic             start, evaluate, in_range, take, finish;
    logic [31:0]      idx_ext, base_mag;

    always_comb begin
        idx_ext      = 32'(bin_index);
        start        = bin_valid & bin_sof;
        evaluate     = bin_valid & (start | (state_q == SEARCH));
        in_range     = (idx_ext >= 32'(MIN_BIN)) && (idx_ext <= 32'(MAX_BIN)) && (idx_ext < 32'(N_FFT));
        base_mag     = start ? 32'd0 : best_mag_q;
        take         = evaluate & in_range & (bin_mag > base_mag);
        finish       = evaluate & bin_last;
        best_mag_d   = take ? bin_mag : base_mag;
        best_idx_d   = take ? bin_index : (start ? '0 : best_idx_q);
        best_phase_d = take ? bin_phase : (start ? 17'd0 : best_phase_q);
        found_d      = take | (~start & found_q);
        state_d      = finish ? DONE : ((start | (state_q == SEARCH)) ? SEARCH : IDLE);
        max_done_d   = finish;
        frame_err_d  = start & (state_q == SEARCH);
        theta_d      = finish ? best_phase_d : theta_q;
        peak_index_d = finish ? best_idx_d : peak_index_q;
        peak_mag_d   = finish ? best_mag_d : peak_mag_q;
        peak_valid_d = finish ? (found_d && (best_mag_d >= MAG_THRESH)) : peak_valid_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            best_mag_q   <= '0;
            best_idx_q   <= '0;
            best_phase_q <= '0;
            found_q      <= 1'b0;
            theta_q      <= '0;
            peak_index_q <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            max_done_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_mag_q   <= best_mag_d;
            best_idx_q   <= best_idx_d;
            best_phase_q <= best_phase_d;
            found_q      <= found_d;
            theta_q      <= theta_d;
            peak_index_q <= peak_index_d;
            peak_mag_q   <= peak_mag_d;
            peak_valid_q <= peak_valid_d;
            max_done_q   <= max_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign theta_o    = theta_q;
    assign peak_index = peak_index_q;
    assign peak_mag   = peak_mag_q;
    assign peak_valid = peak_valid_q;
    assign max_done   = max_done_q;
    assign frame_err  = frame_err_q;
endmodule

// File: doc/fft_peak_phase.md
FFT_PEAK_PHASE -- requirements
Module: fft_peak_phase

Interface
REQ-001 The block SHALL provide parameter N_FFT, default 1024, meaning FFT length in bins.
REQ-002 The block SHALL provide parameter IDX_W, default 10, meaning bin index width (log2 N_FFT).
REQ-003 The block SHALL provide parameter MIN_BIN, default 1, meaning lowest bin eligible for the peak (excludes DC).
REQ-004 The block SHALL provide parameter MAX_BIN, default 511, meaning highest bin eligible for the peak (N_FFT/2-1).
REQ-005 The block SHALL provide parameter MAG_THRESH, default 32'd1024, meaning minimum peak magnitude for a valid peak.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning system clock.
REQ-007 The block SHALL have port rst, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-008 The block SHALL have port bin_valid, input, 1 bit, meaning bin fields valid this cycle.
REQ-009 The block SHALL have port bin_sof, input, 1 bit, meaning first bin of a frame, qualified by bin_valid.
REQ-010 The block SHALL have port bin_last, input, 1 bit, meaning final bin of a frame, qualified by bin_valid.
REQ-011 The block SHALL have port bin_index, input, IDX_W bits, meaning bin number, unsigned.
REQ-012 The block SHALL have port bin_mag, input, 32 bits, meaning squared magnitude, unsigned.
REQ-013 The block SHALL have port bin_phase, input, 17 bits, meaning bin phase, signed two's complement, full scale +/-pi.
REQ-014 The block SHALL have port theta_o, output, 17 bits, meaning phase of the peak bin.
REQ-015 The block SHALL have port peak_index, output, IDX_W bits, meaning bin number of the peak.
REQ-016 The block SHALL have port peak_mag, output, 32 bits, meaning magnitude of the peak.
REQ-017 The block SHALL have port peak_valid, output, 1 bit, meaning the peak met MAG_THRESH.
REQ-018 The block SHALL have port max_done, output, 1 bit, meaning one-cycle pulse when outputs update.
REQ-019 The block SHALL have port frame_err, output, 1 bit, meaning one-cycle pulse when a frame is aborted.

Function
REQ-020 The FSM SHALL have states IDLE, SEARCH and DONE.
REQ-021 IDLE SHALL ignore bins until bin_valid&bin_sof, then clear best_mag/best_idx/best_phase/found, evaluate that bin, and go to SEARCH.
REQ-022 In SEARCH, each bin_valid bin with MIN_BIN<=bin_index<=MAX_BIN and bin_mag>best_mag (strict) SHALL replace the best; equal magnitudes keep the earlier bin.
REQ-023 Out-of-range bins SHALL be ignored for comparison but SHALL still honour bin_last.
REQ-024 On bin_valid&bin_last, the FSM SHALL go to DONE after evaluating that bin.
REQ-025 bin_sof&bin_last in the same cycle SHALL be treated as a single-bin frame.
REQ-026 bin_valid&bin_sof while in SEARCH SHALL abort the current frame, pulse frame_err for one cycle, and restart the search with that bin without issuing max_done.
REQ-027 DONE SHALL last one cycle: register theta_o=best_phase, peak_index=best_idx, peak_mag=best_mag, peak_valid=found&&(best_mag>=MAG_THRESH), assert max_done for exactly that one cycle, then go to IDLE.
REQ-028 Latency SHALL be fixed: max_done is high during the cycle after the edge that samples bin_last, and the outputs are valid in that same cycle.
REQ-029 In DONE, bin_valid&bin_sof SHALL start a new frame as in IDLE, going to SEARCH, while still completing the current result; non-sof bins in DONE or IDLE SHALL be dropped.
REQ-030 theta_o, peak_index, peak_mag and peak_valid SHALL hold until the next max_done.
REQ-031 No frame-length counter SHALL be used; frame extent SHALL be defined only by sof/last.

Reset
REQ-032 rst low SHALL asynchronously force IDLE and clear theta_o, peak_index, peak_mag, peak_valid, max_done, frame_err and all best registers to 0.
REQ-033 Reset mid-frame SHALL discard the frame; after release, no max_done SHALL occur until a full sof..last frame completes.

Verification
REQ-034 Frame bins 0..511, bin 0 mag 9000, bin 50 mag 5000 phase 17'h04000, others 100 -> max_done 1 cycle after last, peak_index 50, theta_o 17'h04000, peak_valid 1.
REQ-035 Bins 20 and 30 both mag 7000 -> peak_index 20.
REQ-036 All mags 500 (below 1024) -> max_done pulses, peak_valid 0, peak_mag 500, peak_index 1.
REQ-037 sof at bin 0, bins to 200, then new sof -> frame_err pulse, no max_done; new frame completes normally and reports only its own peak.
REQ-038 Single-bin frame (sof&last, index 5, mag 2000) -> peak_index 5, peak_valid 1; new sof the cycle after last -> both frames report correctly.
REQ-039 rst low at bin 300 of a frame -> all outputs 0 immediately; bins to last produce no max_done.
